// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the UART receive path: line-control bit positions,
// FIFO record geometry, receiver FSM states and small frame-format helpers.
package uart_receiver_pkg;

    // Line control register bit positions
    localparam int UART_LC_BITS_LO = 0;
    localparam int UART_LC_SB      = 2;
    localparam int UART_LC_PE      = 3;
    localparam int UART_LC_EP      = 4;
    localparam int UART_LC_SP      = 5;

    // RX FIFO geometry: record is {data[7:0], break, parity error, framing error}
    localparam int UART_FIFO_COUNTER_W  = 5;
    localparam int UART_FIFO_REC_WIDTH  = 11;

    typedef enum logic [2:0] {
        r_idle      = 3'd0,
        r_start     = 3'd1,
        r_data      = 3'd2,
        r_parity    = 3'd3,
        r_stop      = 3'd4,
        r_push      = 3'd5,
        r_wait_high = 3'd6
    } rx_state_e;

    // Number of data bits in a frame for the lcr word-length field
    function automatic logic [3:0] data_bits(input logic [1:0] wl);
        return 4'd5 + {2'b00, wl};
    endfunction

    // Expected parity bit for {EP,SP}: odd, stick-1, even, stick-0
    function automatic logic parity_expected(input logic [7:0] d,
                                             input logic       ep,
                                             input logic       sp);
        logic p;
        case ({ep, sp})
            2'b00:   p = ~^d;
            2'b01:   p = 1'b1;
            2'b10:   p = ^d;
            default: p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_rfifo.sv
// RX FIFO: first-word fall-through, power-of-two depth. A push while full is
// rejected even when a pop happens in the same clock; a pop while empty is ignored.
module uart_rfifo
    import uart_receiver_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int FIFO_COUNTER_W = UART_FIFO_COUNTER_W,
    parameter int WIDTH          = UART_FIFO_REC_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          data_in,
    input  logic                      push,
    input  logic                      pop,
    output logic [WIDTH-1:0]          data_out,
    output logic [FIFO_COUNTER_W-1:0] count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0]          mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [FIFO_COUNTER_W-1:0] count_q, count_d;
    logic                      do_push, do_pop;

    // Qualify push/pop against occupancy and advance pointers/count
    always_comb begin
        do_push  = push && (count_q < FIFO_COUNTER_W'(FIFO_DEPTH));
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only observable through a non-zero count
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count    = count_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: synchronises the serial pin, deserialises frames at the
// 16x baud tick, checks parity/stop/break and queues results in the RX FIFO.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int FIFO_COUNTER_W = UART_FIFO_COUNTER_W,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [7:0]                     lcr,
    input  logic                           enable,
    input  logic                           srx_pad_i,
    input  logic                           rf_pop,
    output logic [UART_FIFO_REC_WIDTH-1:0] rf_data_out,
    output logic [FIFO_COUNTER_W-1:0]      rf_count,
    output logic                           rf_overrun,
    output logic                           rx_busy
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_s;
    rx_state_e              state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_bit_q, par_bit_d;
    logic                   pe_q, pe_d;
    logic                   fe_q, fe_d;
    logic                   be_q, be_d;
    logic [3:0]             nbits;
    logic                   push;
    logic                   unused_lcr;

    assign rx_s       = sync_q[SYNC_STAGES-1];
    assign nbits      = data_bits(lcr[1:0]);
    // Stop-bit count and the upper lcr bits do not affect reception
    assign unused_lcr = ^{lcr[7:6], lcr[UART_LC_SB]};

    // Next-state logic: frame sequencing on baud ticks, data/flag capture
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], srx_pad_i};
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_bit_d = par_bit_q;
        pe_d      = pe_q;
        fe_d      = fe_q;
        be_d      = be_q;
        case (state_q)
            r_idle: begin
                if (enable && !rx_s) begin
                    cnt_d   = 4'd7;
                    state_d = r_start;
                end
            end
            r_start: begin
                if (enable) begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else if (rx_s) begin
                        // Start bit did not last to mid-bit: treat as a glitch
                        state_d = r_idle;
                    end else begin
                        cnt_d     = 4'd15;
                        bit_idx_d = 3'd0;
                        shift_d   = 8'h00;
                        par_bit_d = 1'b0;
                        pe_d      = 1'b0;
                        state_d   = r_data;
                    end
                end
            end
            r_data: begin
                if (enable) begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        shift_d[bit_idx_q] = rx_s;
                        cnt_d              = 4'd15;
                        bit_idx_d          = bit_idx_q + 3'd1;
                        if ({1'b0, bit_idx_q} == nbits - 4'd1) begin
                            state_d = lcr[UART_LC_PE] ? r_parity : r_stop;
                        end
                    end
                end
            end
            r_parity: begin
                if (enable) begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        par_bit_d = rx_s;
                        pe_d      = rx_s != parity_expected(shift_q, lcr[UART_LC_EP],
                                                            lcr[UART_LC_SP]);
                        cnt_d     = 4'd15;
                        state_d   = r_stop;
                    end
                end
            end
            r_stop: begin
                if (enable) begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        fe_d    = !rx_s;
                        // par_bit_q stays 0 when parity is disabled
                        be_d    = (shift_q == 8'h00) && !par_bit_q && !rx_s;
                        state_d = r_push;
                    end
                end
            end
            r_push: begin
                state_d = be_q ? r_wait_high : r_idle;
            end
            r_wait_high: begin
                if (enable && rx_s) begin
                    state_d = r_idle;
                end
            end
            default: begin
                state_d = r_idle;
            end
        endcase
    end

    // Control registers: synchroniser, FSM state, sample counter, bit index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q    <= '1;
            state_q   <= r_idle;
            cnt_q     <= 4'd0;
            bit_idx_q <= 3'd0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    // Frame data and status flags; always rewritten before they are used
    always_ff @(posedge clk) begin
        shift_q   <= shift_d;
        par_bit_q <= par_bit_d;
        pe_q      <= pe_d;
        fe_q      <= fe_d;
        be_q      <= be_d;
    end

    assign push       = (state_q == r_push);
    assign rf_overrun = push && (rf_count == FIFO_COUNTER_W'(FIFO_DEPTH));
    assign rx_busy    = (state_q != r_idle);

    uart_rfifo #(
        .FIFO_DEPTH     (FIFO_DEPTH),
        .FIFO_COUNTER_W (FIFO_COUNTER_W),
        .WIDTH          (UART_FIFO_REC_WIDTH)
    ) u_rfifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  ({shift_q, be_q, pe_q, fe_q}),
        .push     (push),
        .pop      (rf_pop),
        .data_out (rf_data_out),
        .count    (rf_count)
    );

endmodule

// File: tb/tb_uart_receiver.sv
// Testbench for uart_receiver: serial frames are driven on srx_pad_i, the
// expected FIFO records are queued as frames are sent and compared on readout.
module tb_uart_receiver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  lcr;
    logic        enable;
    logic        srx_pad_i;
    logic        rf_pop;
    logic [10:0] rf_data_out;
    logic [4:0]  rf_count;
    logic        rf_overrun;
    logic        rx_busy;

    int          checks = 0;
    int          errors = 0;
    int          tick_div = 16;
    int          ovr_cnt = 0;
    logic [10:0] exp_q[$];
    logic [10:0] exp_v;

    uart_receiver dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lcr         (lcr),
        .enable      (enable),
        .srx_pad_i   (srx_pad_i),
        .rf_pop      (rf_pop),
        .rf_data_out (rf_data_out),
        .rf_count    (rf_count),
        .rf_overrun  (rf_overrun),
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;

    // 16x baud tick, one clk wide, every tick_div clks
    initial begin
        enable = 1'b0;
        forever begin
            @(negedge clk);
            enable = 1'b1;
            @(negedge clk);
            enable = 1'b0;
            repeat (tick_div - 2) @(negedge clk);
        end
    end

    // Count overrun pulses
    always @(negedge clk) begin
        if (rf_overrun) ovr_cnt = ovr_cnt + 1;
    end

    // Global time bound
    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete within 90000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic wait_ticks(input int n);
        repeat (n * tick_div) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        srx_pad_i = b;
        wait_ticks(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nb, input logic par_en,
                              input logic par_bit, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < nb; i++) drive_bit(d[i]);
        if (par_en) drive_bit(par_bit);
        drive_bit(stop_bit);
    endtask

    task automatic wait_count(input int target, input int budget);
        int n = 0;
        while (rf_count != 5'(target) && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_pop();
        rf_pop = 1'b1;
        @(negedge clk);
        rf_pop = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; lcr = 8'h03; srx_pad_i = 1'b1; rf_pop = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (rf_count !== 5'd0 || rf_data_out !== 11'h000 || rf_overrun !== 1'b0 || rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: count=%0d data=%h ovr=%b busy=%b, required 0/000/0/0",
                     rf_count, rf_data_out, rf_overrun, rx_busy);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_8n1();
        tick_div = 16;
        lcr = 8'h03;
        wait_ticks(2);
        exp_q.push_back({8'hA5, 3'b000});
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
        wait_count(1, 200);
        checks++;
        if (rf_count !== 5'd1) begin
            errors++; $display("FAIL 8n1_count: got %0d required 1", rf_count);
        end
        exp_v = exp_q.pop_front();
        checks++;
        if (rf_data_out !== exp_v) begin
            errors++; $display("FAIL 8n1_data: got %h required %h", rf_data_out, exp_v);
        end
        do_pop();
        checks++;
        if (rf_count !== 5'd0) begin
            errors++; $display("FAIL 8n1_pop_count: got %0d required 0", rf_count);
        end
        tick_div = 4;
        wait_ticks(4);
    endtask

    task automatic test_parity();
        logic [7:0] d;
        logic       ev;
        d  = 8'h37;
        ev = ^d;
        // 8E1 with the wrong parity bit, then with the right one
        lcr = 8'h1B;
        exp_q.push_back({d, 3'b010});
        send_frame(d, 8, 1'b1, ~ev, 1'b1);
        exp_q.push_back({d, 3'b000});
        send_frame(d, 8, 1'b1, ev, 1'b1);
        // Stick parity 1 (PE=1, SP=1, EP=0) with a 1 parity bit
        lcr = 8'h2B;
        exp_q.push_back({d, 3'b000});
        send_frame(d, 8, 1'b1, 1'b1, 1'b1);
        // Stick parity 0 (PE=1, SP=1, EP=1) with a 1 parity bit
        lcr = 8'h3B;
        exp_q.push_back({d, 3'b010});
        send_frame(d, 8, 1'b1, 1'b1, 1'b1);
        wait_count(4, 200);
        checks++;
        if (rf_count !== 5'd4) begin
            errors++; $display("FAIL parity_count: got %0d required 4", rf_count);
        end
        for (int i = 0; i < 4; i++) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (rf_data_out !== exp_v) begin
                errors++; $display("FAIL parity_entry%0d: got %h required %h", i, rf_data_out, exp_v);
            end
            do_pop();
        end
    endtask

    task automatic test_framing_break();
        lcr = 8'h02;
        exp_q.push_back({8'h41, 3'b001});
        send_frame(8'h41, 7, 1'b0, 1'b0, 1'b0);
        srx_pad_i = 1'b1;
        wait_ticks(16);
        checks++;
        if (rf_count !== 5'd1 || rx_busy !== 1'b0) begin
            errors++; $display("FAIL fe_count_busy: count=%0d busy=%b required 1/0", rf_count, rx_busy);
        end
        exp_v = exp_q.pop_front();
        checks++;
        if (rf_data_out !== exp_v) begin
            errors++; $display("FAIL fe_entry: got %h required %h", rf_data_out, exp_v);
        end
        do_pop();
        // Break: all-zero frame with the line held low afterwards
        exp_q.push_back({8'h00, 3'b101});
        send_frame(8'h00, 7, 1'b0, 1'b0, 1'b0);
        wait_ticks(40);
        checks++;
        if (rx_busy !== 1'b1 || rf_count !== 5'd1) begin
            errors++; $display("FAIL break_hold: busy=%b count=%0d required 1/1", rx_busy, rf_count);
        end
        srx_pad_i = 1'b1;
        wait_ticks(3);
        checks++;
        if (rx_busy !== 1'b0 || rf_count !== 5'd1) begin
            errors++; $display("FAIL break_release: busy=%b count=%0d required 0/1", rx_busy, rf_count);
        end
        exp_v = exp_q.pop_front();
        checks++;
        if (rf_data_out !== exp_v) begin
            errors++; $display("FAIL break_entry: got %h required %h", rf_data_out, exp_v);
        end
        do_pop();
    endtask

    task automatic test_glitch();
        lcr = 8'h03;
        srx_pad_i = 1'b0;
        wait_ticks(3);
        checks++;
        if (rx_busy !== 1'b1) begin
            errors++; $display("FAIL glitch_busy: got %b required 1", rx_busy);
        end
        wait_ticks(1);
        srx_pad_i = 1'b1;
        wait_ticks(12);
        checks++;
        if (rx_busy !== 1'b0 || rf_count !== 5'd0) begin
            errors++; $display("FAIL glitch_abort: busy=%b count=%0d required 0/0", rx_busy, rf_count);
        end
    endtask

    task automatic test_overrun();
        int         base;
        logic [7:0] d;
        lcr  = 8'h03;
        base = ovr_cnt;
        for (int i = 0; i < 16; i++) begin
            d = 8'(i * 13 + 5);
            exp_q.push_back({d, 3'b000});
            send_frame(d, 8, 1'b0, 1'b0, 1'b1);
        end
        checks++;
        if (rf_count !== 5'd16 || ovr_cnt - base !== 0) begin
            errors++; $display("FAIL fill: count=%0d overruns=%0d required 16/0", rf_count, ovr_cnt - base);
        end
        send_frame(8'hEE, 8, 1'b0, 1'b0, 1'b1);
        checks++;
        if (rf_count !== 5'd16 || ovr_cnt - base !== 1) begin
            errors++; $display("FAIL overrun: count=%0d overruns=%0d required 16/1", rf_count, ovr_cnt - base);
        end
        for (int i = 0; i < 4; i++) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (rf_data_out !== exp_v) begin
                errors++; $display("FAIL ovr_read%0d: got %h required %h", i, rf_data_out, exp_v);
            end
            do_pop();
        end
        // Refill across the pointer wrap
        for (int i = 0; i < 4; i++) begin
            d = 8'(8'hF0 + i);
            exp_q.push_back({d, 3'b000});
            send_frame(d, 8, 1'b0, 1'b0, 1'b1);
        end
        checks++;
        if (rf_count !== 5'd16) begin
            errors++; $display("FAIL wrap_count: got %0d required 16", rf_count);
        end
        for (int i = 0; i < 16; i++) begin
            exp_v = exp_q.pop_front();
            checks++;
            if (rf_data_out !== exp_v) begin
                errors++; $display("FAIL wrap_read%0d: got %h required %h", i, rf_data_out, exp_v);
            end
            do_pop();
        end
        checks++;
        if (rf_count !== 5'd0 || rf_data_out !== 11'h000) begin
            errors++; $display("FAIL drain: count=%0d data=%h required 0/000", rf_count, rf_data_out);
        end
    endtask

    task automatic test_reset_mid_frame();
        lcr = 8'h03;
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
        // Start bit, then part of the first data bit
        srx_pad_i = 1'b0;
        wait_ticks(16);
        srx_pad_i = 1'b1;
        wait_ticks(8);
        checks++;
        if (rx_busy !== 1'b1 || rf_count !== 5'd1) begin
            errors++; $display("FAIL pre_reset: busy=%b count=%0d required 1/1", rx_busy, rf_count);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (rx_busy !== 1'b0 || rf_count !== 5'd0 || rf_data_out !== 11'h000 || rf_overrun !== 1'b0) begin
            errors++; $display("FAIL mid_reset: busy=%b count=%0d data=%h ovr=%b required 0/0/000/0",
                               rx_busy, rf_count, rf_data_out, rf_overrun);
        end
        rst_n = 1'b1;
        wait_ticks(32);
        checks++;
        if (rf_count !== 5'd0) begin
            errors++; $display("FAIL post_reset_idle: count=%0d required 0", rf_count);
        end
        exp_q.push_back({8'hC3, 3'b000});
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1);
        wait_count(1, 200);
        checks++;
        if (rf_count !== 5'd1) begin
            errors++; $display("FAIL post_reset_count: got %0d required 1", rf_count);
        end
        exp_v = exp_q.pop_front();
        checks++;
        if (rf_data_out !== exp_v) begin
            errors++; $display("FAIL post_reset_entry: got %h required %h", rf_data_out, exp_v);
        end
        do_pop();
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_framing_break();
        test_glitch();
        test_overrun();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
